mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin controller that shares one sequential multiplier unit among NREQ requesters. It arbitrates requests, loads the winner's operands into the unit, pulses the unit's init, waits for completion, and returns the 2N-bit product to the granted requester with a one-cycle done pulse. A watchdog aborts a dispatch whose completion never arrives. The block sits between the requesting datapath blocks and the single shared multiplier.

## Interface
- N, default 8: operand width; the product is 2N bits.
- NREQ, default 4: number of requesters, at least 2.
- TIMEOUT, default 1024: maximum number of WAIT cycles per dispatch; at least 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request level; the requester holds it with operands stable until its gnt bit pulses.
- op_a  in  NREQ*N  packed operand A; requester i uses [i*N +: N].
- op_b  in  NREQ*N  packed operand B, same packing as op_a.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands of requester i were captured.
- done  out  NREQ  one-hot, one-cycle pulse; result and err are valid for requester i.
- result  out  2N  product; updated only when done pulses and held afterwards.
- err  out  1  high with done when the dispatch timed out.
- busy  out  1  high in every state except IDLE.
- unit_init  out  1  one-cycle start pulse to the shared unit.
- unit_a  out  N  operand A to the unit; held from ISSUE until the next ISSUE.
- unit_b  out  N  operand B to the unit, same rule as unit_a.
- unit_finished  in  1  completion flag from the unit; may stay high between operations.
- unit_result  in  2N  product from the unit; valid while unit_finished is high.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - If req is nonzero, select index idx by round-robin.
  - Search starts at (last + 1) mod NREQ and wraps; last is the most recently served index.
  - Latch op_a/op_b slice idx into unit_a/unit_b, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE (one cycle)
  - gnt[idx] = 1 and unit_init = 1.
  - Clear the watchdog counter and the arm flag, then go to WAIT.
- WAIT
  - Each cycle: if unit_finished = 0, set arm.
  - If unit_finished = 1 and arm = 1, this is completion: capture unit_result into result, err = 0, go to DONE.
  - Otherwise, if counter = TIMEOUT-1: result = 0, err = 1, go to DONE.
  - Otherwise, increment the counter.
  - Completion takes priority over timeout in the same cycle.
- DONE (one cycle)
  - done[idx] = 1, last = idx, go to IDLE.
- The arm rule means a unit that leaves unit_finished high from its previous operation never causes an early completion.
- req is sampled only in IDLE; changes to req in other states are ignored.
- A req still high in IDLE after DONE is treated as a new request.
- gnt, done, unit_init and err are all registered outputs.

## Timing
- Reset values (immediate on rst_n low, in any state): state IDLE, last = NREQ-1 (requester 0 has top priority), gnt = 0, done = 0, result = 0, err = 0, busy = 0, unit_init = 0, unit_a = 0, unit_b = 0, counter = 0, arm = 0.
- Reset mid-operation abandons the dispatch: no done is issued. The shared unit is reset by the same rst_n.
- Cycle numbering: req first seen in IDLE at edge k.
  - ISSUE (gnt and unit_init high) in cycle k+1.
  - WAIT starts in cycle k+2.
  - If completion is sampled at edge m, done is high in cycle m+1.
  - The next IDLE is cycle m+2, so back-to-back dispatch spacing is at least 4 cycles.
- Timeout: WAIT lasts exactly TIMEOUT cycles; done with err = 1 is high in cycle k+TIMEOUT+2.
- busy is high from ISSUE through DONE inclusive.

## Test plan
- Single request: req[0] = 1, a = 3, b = 5; the unit model finishes 6 cycles after init → gnt[0] in cycle k+1 with unit_a = 3, unit_b = 5; done[0] with result = 15, err = 0.
- Simultaneous requests: all four req high, operands (2,3), (4,5), (6,7), (255,255) → grant order 0,1,2,3; results 6, 20, 42, 65025.
- Fairness: req[0] and req[2] re-asserted immediately after each gnt → grant order 0,2,0,2, with no repeat of the same index while the other is pending.
- Sticky finished: the unit holds unit_finished high between operations → no done until unit_finished drops and rises again; the result equals the second product.
- Timeout: TIMEOUT = 16, unit_finished held at 0 → done[idx] with err = 1 and result = 0 exactly 16 WAIT cycles after ISSUE; the next request is served normally.
- Reset mid-WAIT: rst_n pulsed low → all outputs 0 immediately with no done pulse; after release, req = 4'b1010 → gnt[1] first.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// Requester-side bus of the shared multiplier arbiter.
interface mult_share_arbiter_if #(
  parameter int N    = 8,
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] op_a;
  logic [NREQ*N-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [2*N-1:0]    result;
  logic              err;
  logic              busy;

  // requesters drive requests and operands
  modport master (
    output req, op_a, op_b,
    input  gnt, done, result, err, busy
  );

  // arbiter side
  modport slave (
    input  req, op_a, op_b,
    output gnt, done, result, err, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin controller sharing one sequential multiplier among NREQ
// requesters, with a watchdog that aborts dispatches that never complete.
module mult_share_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus,
  output logic                 unit_init,
  output logic [N-1:0]         unit_a,
  output logic [N-1:0]         unit_b,
  input  logic                 unit_finished,
  input  logic [2*N-1:0]       unit_result
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   idx, last, sel_idx;
  logic            sel_valid;
  logic [N-1:0]    sel_a, sel_b;
  logic [CW-1:0]   cnt;
  logic            arm;
  logic            complete, expire;
  logic [NREQ-1:0] gnt_nxt, done_nxt;
  logic            init_nxt;

  // round-robin pick: first requester after the last one served, wrapping
  always_comb begin
    int unsigned j;
    sel_idx   = last;
    sel_valid = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      j = int'(last) + off;
      if (j >= NREQ) j = j - NREQ;
      if (!sel_valid && bus.req[IW'(j)]) begin
        sel_idx   = IW'(j);
        sel_valid = 1'b1;
      end
    end
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == sel_idx) begin
        sel_a = bus.op_a[i*N +: N];
        sel_b = bus.op_b[i*N +: N];
      end
    end
  end

  // completion needs a low level seen first; it beats timeout in the same cycle
  always_comb begin
    complete = unit_finished && arm;
    expire   = !complete && (cnt == CW'(TIMEOUT - 1));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (complete || expire) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output decode: next values of the registered pulses, plus busy
  always_comb begin
    gnt_nxt  = '0;
    done_nxt = '0;
    init_nxt = 1'b0;
    bus.busy = (state != IDLE);
    case (state)
      IDLE: if (sel_valid) begin
        gnt_nxt  = NREQ'(1) << sel_idx;
        init_nxt = 1'b1;
      end
      WAIT: if (complete || expire) done_nxt = NREQ'(1) << idx;
      default: ;
    endcase
  end

  // registered outputs, operand latch, watchdog and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.result <= '0;
      bus.err    <= 1'b0;
      unit_init  <= 1'b0;
      unit_a     <= '0;
      unit_b     <= '0;
      idx        <= '0;
      last       <= IW'(NREQ - 1);
      cnt        <= '0;
      arm        <= 1'b0;
    end else begin
      bus.gnt   <= gnt_nxt;
      bus.done  <= done_nxt;
      unit_init <= init_nxt;
      case (state)
        IDLE: if (sel_valid) begin
          idx    <= sel_idx;
          unit_a <= sel_a;
          unit_b <= sel_b;
        end
        ISSUE: begin
          cnt <= '0;
          arm <= 1'b0;
        end
        WAIT: begin
          if (!unit_finished) arm <= 1'b1;
          if (complete) begin
            bus.result <= unit_result;
            bus.err    <= 1'b0;
          end else if (expire) begin
            bus.result <= '0;
            bus.err    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          last    <= idx;
          bus.err <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier unit.
module tb_mult_share_arbiter;
  localparam int N       = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;
  localparam int M_NORM   = 0;
  localparam int M_STICKY = 1;
  localparam int M_DEAD   = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic unit_init;
  logic [N-1:0] unit_a, unit_b;
  logic unit_finished;
  logic [2*N-1:0] unit_result;

  int total = 0;
  int bad   = 0;
  int model_last;
  int umode, ulat, uhold;
  int ucnt, hcnt;
  logic [N-1:0] pa, pb;

  mult_share_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

  mult_share_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .unit_init(unit_init), .unit_a(unit_a), .unit_b(unit_b),
    .unit_finished(unit_finished), .unit_result(unit_result)
  );

  always #5 clk = ~clk;

  // shared multiplier model: NORM drops finished on init and raises it ulat
  // cycles later; STICKY keeps a stale finished high uhold cycles first; DEAD never finishes
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_finished <= 1'b0; unit_result <= '0; ucnt <= 0; hcnt <= 0; pa <= '0; pb <= '0;
    end else if (unit_init) begin
      pa <= unit_a; pb <= unit_b;
      if (umode == M_DEAD) begin
        unit_finished <= 1'b0; ucnt <= 0; hcnt <= 0;
      end else if (umode == M_STICKY && unit_finished) begin
        hcnt <= uhold; ucnt <= 0;
      end else begin
        unit_finished <= 1'b0; ucnt <= ulat; hcnt <= 0;
      end
    end else if (hcnt != 0) begin
      hcnt <= hcnt - 1;
      if (hcnt == 1) begin unit_finished <= 1'b0; ucnt <= ulat; end
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) begin unit_finished <= 1'b1; unit_result <= 16'(pa) * 16'(pb); end
    end
  end

  typedef struct {
    bit rst; logic [3:0] raise; logic [3:0] keep;
    logic [31:0] a_all; logic [31:0] b_all;
    int mode; int lat; int hold;
    int exp_idx; logic [15:0] exp_res; logic exp_err; int exp_lat;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // priority order: indices above last ascending, then from 0 up to last
  function automatic int rr_pick(input logic [NREQ-1:0] rq, input int last);
    for (int i = last + 1; i < NREQ; i++) if (rq[i]) return i;
    for (int i = 0; i <= last; i++) if (rq[i]) return i;
    return -1;
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, " gnt"}, bus.gnt, 0);     chk({nm, " done"}, bus.done, 0);
    chk({nm, " result"}, bus.result, 0); chk({nm, " err"}, bus.err, 0);
    chk({nm, " busy"}, bus.busy, 0);   chk({nm, " init"}, unit_init, 0);
    chk({nm, " unit_a"}, unit_a, 0);   chk({nm, " unit_b"}, unit_b, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = '0;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = NREQ - 1;
    @(negedge clk);
  endtask

  // call at a negedge in IDLE with req pending; returns at a negedge in IDLE
  task automatic serve(input string nm, input int exp_idx, input logic [15:0] exp_res,
                       input logic exp_err, input int exp_lat, input logic [3:0] keep);
    int n;
    logic [N-1:0] ea, eb;
    ea = bus.op_a[exp_idx*N +: N];
    eb = bus.op_b[exp_idx*N +: N];
    @(negedge clk);
    chk({nm, " gnt"}, bus.gnt, 64'(1) << exp_idx);
    chk({nm, " init"}, unit_init, 1);
    chk({nm, " unit_a"}, unit_a, ea);
    chk({nm, " unit_b"}, unit_b, eb);
    chk({nm, " busy"}, bus.busy, 1);
    bus.req = bus.req & (~(4'b0001 << exp_idx) | keep);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk({nm, " gnt pulse"}, bus.gnt, 0);
        chk({nm, " init pulse"}, unit_init, 0);
      end
    end while (bus.done == 0 && n < 40);
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " done"}, bus.done, 64'(1) << exp_idx);
    chk({nm, " result"}, bus.result, exp_res);
    chk({nm, " err"}, bus.err, exp_err);
    chk({nm, " unit_a held"}, unit_a, ea);
    @(negedge clk);
    chk({nm, " done pulse"}, bus.done, 0);
    chk({nm, " idle busy"}, bus.busy, 0);
    model_last = exp_idx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, idx, lat, hold, mode, elat;
    logic [15:0] eres;
    rst_n = 1'b1;
    bus.req = '0; bus.op_a = '0; bus.op_b = '0;
    umode = M_NORM; ulat = 1; uhold = 1;

    //         rst raise    keep     a_all         b_all         mode      lat hold idx res    err lat
    tbl[0]  = '{1, 4'b0001, 4'b0000, 32'h00000003, 32'h00000005, M_NORM,   6, 0, 0, 16'd15,    0, 8};
    tbl[1]  = '{1, 4'b1111, 4'b0000, 32'hFF060402, 32'hFF070503, M_NORM,   2, 0, 0, 16'd6,     0, 4};
    tbl[2]  = '{0, 4'b0000, 4'b0000, 32'hFF060402, 32'hFF070503, M_NORM,   3, 0, 1, 16'd20,    0, 5};
    tbl[3]  = '{0, 4'b0000, 4'b0000, 32'hFF060402, 32'hFF070503, M_NORM,   4, 0, 2, 16'd42,    0, 6};
    tbl[4]  = '{0, 4'b0000, 4'b0000, 32'hFF060402, 32'hFF070503, M_NORM,   5, 0, 3, 16'd65025, 0, 7};
    tbl[5]  = '{1, 4'b0101, 4'b0101, 32'h00050003, 32'h00060004, M_NORM,   1, 0, 0, 16'd12,    0, 3};
    tbl[6]  = '{0, 4'b0000, 4'b0101, 32'h00050003, 32'h00060004, M_NORM,   1, 0, 2, 16'd30,    0, 3};
    tbl[7]  = '{0, 4'b0000, 4'b0101, 32'h00050003, 32'h00060004, M_NORM,   1, 0, 0, 16'd12,    0, 3};
    tbl[8]  = '{0, 4'b0000, 4'b0001, 32'h00050003, 32'h00060004, M_NORM,   1, 0, 2, 16'd30,    0, 3};
    tbl[9]  = '{1, 4'b0001, 4'b0000, 32'h00000009, 32'h00000009, M_NORM,   2, 0, 0, 16'd81,    0, 4};
    tbl[10] = '{0, 4'b0010, 4'b0000, 32'h00000700, 32'h00000B00, M_STICKY, 3, 5, 1, 16'd77,    0, 10};
    tbl[11] = '{0, 4'b0100, 4'b0000, 32'h000A0000, 32'h000A0000, M_DEAD,   0, 0, 2, 16'd0,     1, TIMEOUT + 1};
    tbl[12] = '{0, 4'b1000, 4'b0000, 32'h0C000000, 32'h0D000000, M_NORM,   4, 0, 3, 16'd156,   0, 6};

    #2;
    do_reset();
    for (int r = 0; r < 13; r++) begin
      if (tbl[r].rst) do_reset();
      bus.op_a = tbl[r].a_all;
      bus.op_b = tbl[r].b_all;
      umode = tbl[r].mode; ulat = tbl[r].lat; uhold = tbl[r].hold;
      bus.req = bus.req | tbl[r].raise;
      serve($sformatf("row%0d", r), tbl[r].exp_idx, tbl[r].exp_res,
            tbl[r].exp_err, tbl[r].exp_lat, tbl[r].keep);
    end

    // reset in the middle of WAIT abandons the dispatch
    bus.op_a = 32'h00000014; bus.op_b = 32'h0000001E;
    umode = M_NORM; ulat = 10;
    bus.req = 4'b0001;
    @(negedge clk);
    chk("midrst gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("midrst busy before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) begin
      @(negedge clk);
      chk("midrst no done", bus.done, 0);
    end
    rst_n = 1'b1;
    model_last = NREQ - 1;
    bus.op_a = 32'h05000700; bus.op_b = 32'h06000800;
    ulat = 2;
    bus.req = 4'b1010;
    serve("midrst first", 1, 16'd56, 0, 4, 4'b0000);
    serve("midrst second", 3, 16'd30, 0, 4, 4'b0000);

    // randomized dispatches against the round-robin reference
    do_reset();
    for (int it = 0; it < 50; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req[i] && $urandom_range(1, 0) == 1) begin
          bus.op_a[i*N +: N] = N'($urandom);
          bus.op_b[i*N +: N] = N'($urandom);
          bus.req[i] = 1'b1;
        end
      end
      if (bus.req == 0) begin
        idx = int'($urandom_range(NREQ - 1, 0));
        bus.op_a[idx*N +: N] = N'($urandom);
        bus.op_b[idx*N +: N] = N'($urandom);
        bus.req[idx] = 1'b1;
      end
      m    = int'($urandom_range(9, 0));
      mode = (m < 6) ? M_NORM : (m < 8) ? M_STICKY : M_DEAD;
      lat  = int'($urandom_range(8, 1));
      hold = int'($urandom_range(4, 1));
      umode = mode; ulat = lat; uhold = hold;
      idx = rr_pick(bus.req, model_last);
      if (mode == M_DEAD) begin
        eres = '0;
        elat = TIMEOUT + 1;
      end else begin
        eres = 16'(bus.op_a[idx*N +: N]) * 16'(bus.op_b[idx*N +: N]);
        elat = (mode == M_STICKY && unit_finished) ? hold + lat + 2 : lat + 2;
      end
      serve($sformatf("rand%0d", it), idx, eres, (mode == M_DEAD), elat, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
